// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO. It has an occupancy count, almost-full/almost-empty
// thresholds, a registered read port with a valid strobe, synchronous flush and sticky error flags.
module sync_fifo_param #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AF_THRESH = 6,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  localparam logic [AW:0] ONE_C   = PW'(1);
  localparam logic [AW:0] DEPTH_C = PW'(DEPTH);
  localparam logic [AW:0] AF_C    = PW'(AF_THRESH);
  localparam logic [AW:0] AE_C    = PW'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic full_w, empty_w;
  logic wr_acc, rd_acc;

  // Flags decode only the registered count, so no input reaches an output combinationally.
  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == '0);

  // A flush cycle ignores both requests.
  assign rd_acc = rd_en & ~empty_w & ~clr;
  assign wr_acc = wr_en & (~full_w | rd_acc) & ~clr;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + ONE_C;
      end
      if (rd_acc) begin
        rd_ptr_d   = rd_ptr_q + ONE_C;
        rd_data_d  = mem[rd_ptr_q[AW-1:0]];
        rd_valid_d = 1'b1;
      end
      if (wr_acc && !rd_acc) begin
        count_d = count_q + ONE_C;
      end else if (rd_acc && !wr_acc) begin
        count_d = count_q - ONE_C;
      end
      if (wr_en && full_w && !rd_acc) begin
        overflow_d = 1'b1;
      end
      if (rd_en && empty_w) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset, so it can map onto block RAM. When the FIFO is full and a
  // read and a write arrive together, both use the same slot and the read returns the old word.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (DATA_W=8, DEPTH=8, AF=6, AE=2). It checks
// fill/drain, overflow, pass-through, underflow, wrap, flush and asynchronous reset.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  int checks   = 0;
  int failures = 0;

  sync_fifo_param #(
    .DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of requests, then sample 1 time unit after the edge.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr_en = w; wr_data = d; rd_en = r; clr = c;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
    $display("t=%0t wr=%0b d=%02h rd=%0b clr=%0b -> rd_data=%02h vld=%0b cnt=%0d F=%0b E=%0b AF=%0b AE=%0b ovf=%0b unf=%0b",
             $time, w, d, r, c, rd_data, rd_valid, count, full, empty, almost_full,
             almost_empty, overflow, underflow);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ae", 32'(almost_empty), 32'd1);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_rdvalid", 32'(rd_valid), 32'd0);
    chk("rst_rddata", 32'(rd_data), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_unf", 32'(underflow), 32'd0);
    rst_n = 1'b1;

    // T2: fill 0x10..0x17, then drain in order.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      chk("t2_fill_count", 32'(count), 32'(i + 1));
      chk("t2_fill_af", 32'(almost_full), 32'((i + 1) >= 6));
      chk("t2_fill_ae", 32'(almost_empty), 32'((i + 1) <= 2));
      chk("t2_fill_full", 32'(full), 32'(i == 7));
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t2_drain_valid", 32'(rd_valid), 32'd1);
      chk("t2_drain_data", 32'(rd_data), 32'(8'h10 + i));
      chk("t2_drain_count", 32'(count), 32'(7 - i));
    end
    chk("t2_empty", 32'(empty), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t2_idle_valid", 32'(rd_valid), 32'd0);
    chk("t2_idle_hold", 32'(rd_data), 32'h17);

    // T3: write while full is rejected and makes overflow sticky.
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_count", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t3_drain_data", 32'(rd_data), 32'(8'h20 + i));
    end
    chk("t3_empty", 32'(empty), 32'd1);
    chk("t3_ovf_sticky", 32'(overflow), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t3_clr_ovf", 32'(overflow), 32'd0);

    // T4: when full, a simultaneous read and write both go through.
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    chk("t4_count", 32'(count), 32'd8);
    chk("t4_valid", 32'(rd_valid), 32'd1);
    chk("t4_data", 32'(rd_data), 32'h30);
    chk("t4_ovf", 32'(overflow), 32'd0);
    for (int i = 1; i < 9; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t4_drain_data", 32'(rd_data), (i == 8) ? 32'h55 : 32'(8'h30 + i));
    end
    chk("t4_empty", 32'(empty), 32'd1);

    // T5: a read while empty sets underflow; a read and write together while empty keeps only the write.
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t5_unf", 32'(underflow), 32'd1);
    chk("t5_valid", 32'(rd_valid), 32'd0);
    chk("t5_hold", 32'(rd_data), 32'h55);
    cyc(1'b1, 8'h33, 1'b1, 1'b0);
    chk("t5_count1", 32'(count), 32'd1);
    chk("t5_valid2", 32'(rd_valid), 32'd0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t5_rd33_valid", 32'(rd_valid), 32'd1);
    chk("t5_rd33", 32'(rd_data), 32'h33);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h40 + r * 8 + i), 1'b0, 1'b0);
      chk("t5_wrap_full", 32'(full), 32'd1);
      for (int i = 0; i < 8; i++) begin
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t5_wrap_data", 32'(rd_data), 32'(8'h40 + r * 8 + i));
      end
    end

    // T6: a flush during a write clears everything; underflow is still set from T5.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    chk("t6_pre_count", 32'(count), 32'd5);
    chk("t6_pre_unf", 32'(underflow), 32'd1);
    cyc(1'b1, 8'h77, 1'b0, 1'b1);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_unf", 32'(underflow), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);

    // T1: asserting reset mid-stream clears state asynchronously, before any clock edge.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t1_pre_valid", 32'(rd_valid), 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t1_pre_unf", 32'(underflow), 32'd0);
    rst_n = 1'b0;
    #2;
    chk("t1_count", 32'(count), 32'd0);
    chk("t1_empty", 32'(empty), 32'd1);
    chk("t1_valid", 32'(rd_valid), 32'd0);
    chk("t1_rddata", 32'(rd_data), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b1, 8'h99, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t1_post_data", 32'(rd_data), 32'h99);
    chk("t1_post_empty", 32'(empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
